// File: rtl/apb_conv_pkg.sv
// ---------------------------------------------------------------------------
// apb_conv_pkg
// Shared constants and types for the APB 3x3 convolution peripheral:
//   - datapath widths (coefficient, pixel, tap count, accumulator)
//   - register byte offsets and the matching word indices (PADDR[7:2])
//   - APB phase-tracker state encoding
//   - helper to decide whether a word index falls inside a 9-entry bank
// ---------------------------------------------------------------------------
package apb_conv_pkg;

    localparam int COEF_W = 8;
    localparam int PIX_W  = 8;
    localparam int TAPS   = 9;
    localparam int ACC_W  = 32;

    // Byte offsets of the register map
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_SHIFT  = 8'h08;
    localparam logic [7:0] OFF_RESULT = 8'h0C;
    localparam logic [7:0] OFF_KERNEL = 8'h10;
    localparam logic [7:0] OFF_PIXEL  = 8'h40;

    // Word indices, which is what the decoder actually compares against
    localparam logic [5:0] IDX_CTRL   = OFF_CTRL[7:2];
    localparam logic [5:0] IDX_STATUS = OFF_STATUS[7:2];
    localparam logic [5:0] IDX_SHIFT  = OFF_SHIFT[7:2];
    localparam logic [5:0] IDX_RESULT = OFF_RESULT[7:2];
    localparam logic [5:0] IDX_KERNEL = OFF_KERNEL[7:2];
    localparam logic [5:0] IDX_PIXEL  = OFF_PIXEL[7:2];

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b01,
        S_ACCESS = 2'b10
    } apb_state_t;

    // True when idx addresses one of the TAPS words starting at base
    function automatic logic in_bank(input logic [5:0] idx, input logic [5:0] base);
        return (idx >= base) && (idx < base + 6'(TAPS));
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// ---------------------------------------------------------------------------
// conv_mac_unit
// Sequential signed multiply-accumulate over the 9 taps, one tap per cycle,
// followed by one finishing cycle that applies the arithmetic shift and the
// optional ReLU clamp and publishes RESULT.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle pulse: clear acc and begin a run
//   clear            one-cycle pulse: abort, drop BUSY/DONE, zero RESULT
//   relu_en          clamp negative shifted results to zero
//   shift            arithmetic right-shift amount applied to acc
//   kernel, pixel    tap values (signed coefficients, unsigned pixels)
//   busy, done       run status (done is sticky until start/clear)
//   result           last finished result, held while a new run is busy
// ---------------------------------------------------------------------------
module conv_mac_unit
    import apb_conv_pkg::*;
#(
    parameter int CW = COEF_W,
    parameter int PW = PIX_W,
    parameter int N  = TAPS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   clear,
    input  logic                   relu_en,
    input  logic [4:0]             shift,
    input  logic [N-1:0][CW-1:0]   kernel,
    input  logic [N-1:0][PW-1:0]   pixel,
    output logic                   busy,
    output logic                   done,
    output logic [ACC_W-1:0]       result
);

    localparam int CNT_W  = $clog2(N + 1);
    localparam int PROD_W = CW + PW + 1;
    localparam logic [CNT_W-1:0] TAP_END = CNT_W'(N);

    logic [CNT_W-1:0]         tap_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic [CW-1:0]            coef;
    logic [PW-1:0]            pix;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  shifted;

    // Select the current tap and form its product. The pixel gets a zero
    // sign bit so the multiply is signed x non-negative. When tap_cnt has
    // run past the last tap the selectors fall back to zero, which keeps
    // the mux in range during the finishing cycle.
    always_comb begin
        coef = '0;
        pix  = '0;
        for (int k = 0; k < N; k++) begin
            if (tap_cnt == CNT_W'(k)) begin
                coef = kernel[k];
                pix  = pixel[k];
            end
        end
        product = $signed(coef) * $signed({1'b0, pix});
        shifted = acc >>> shift;
    end

    // Run control. Clear beats start; during a run, taps 0..N-1 are
    // accumulated on successive edges, and the edge after the last tap
    // publishes the shifted/clamped value and raises the sticky done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            acc     <= '0;
            tap_cnt <= '0;
        end else if (clear) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            acc     <= '0;
            tap_cnt <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            done    <= 1'b0;
            acc     <= '0;
            tap_cnt <= '0;
        end else if (busy) begin
            if (tap_cnt != TAP_END) begin
                acc     <= acc + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
                tap_cnt <= tap_cnt + 1'b1;
            end else begin
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= (relu_en && shifted[ACC_W-1]) ? '0 : shifted;
            end
        end
    end

endmodule

// File: rtl/apb_conv_ctrl.sv
// ---------------------------------------------------------------------------
// apb_conv_ctrl
// APB3 slave holding a 3x3 kernel and a 3x3 pixel window; software loads
// the taps, writes START, polls STATUS and reads RESULT.
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   PADDR           byte address, only PADDR[7:2] is decoded
//   PWDATA, PWRITE  write data and direction
//   PSEL, PENABLE   APB select and access-phase strobe
//   PRDATA          read data (zero outside a valid read access)
//   PREADY          PSEL & PENABLE, never any wait state
//   PSLVERR         error response during the access phase
// ---------------------------------------------------------------------------
module apb_conv_ctrl
    import apb_conv_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PSEL,
    input  logic        PENABLE,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    apb_state_t state, state_nxt;

    logic [5:0] widx, k_off, p_off;
    logic       is_ctrl, is_status, is_shift, is_result, is_kernel, is_pixel;
    logic       mapped, access_valid, tap_locked, slv_err, wr_en;
    logic       start_pulse, clear_pulse;
    logic [31:0] rd_value;

    logic [TAPS-1:0][COEF_W-1:0] kernel_q;
    logic [TAPS-1:0][PIX_W-1:0]  pixel_q;
    logic [4:0]                  shift_q;
    logic                        relu_en_q;
    logic                        busy, done;
    logic [ACC_W-1:0]            result;

    logic unused_bits;
    assign unused_bits = ^{PADDR[31:8], PADDR[1:0], PWDATA[31:8]};

    // APB phase tracker. Its only functional job is to tell a genuine
    // access phase (one that followed a SETUP cycle) from a stray PENABLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (PSEL && !PENABLE) state_nxt = S_SETUP;
            S_SETUP:  if (PENABLE) state_nxt = S_ACCESS;
                      else if (!PSEL) state_nxt = S_IDLE;
            S_ACCESS: state_nxt = (PSEL && !PENABLE) ? S_SETUP : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    assign PREADY       = PSEL & PENABLE;
    assign access_valid = PSEL & PENABLE & (state == S_SETUP);

    // Address decode on word index
    assign widx      = PADDR[7:2];
    assign k_off     = widx - IDX_KERNEL;
    assign p_off     = widx - IDX_PIXEL;
    assign is_ctrl   = (widx == IDX_CTRL);
    assign is_status = (widx == IDX_STATUS);
    assign is_shift  = (widx == IDX_SHIFT);
    assign is_result = (widx == IDX_RESULT);
    assign is_kernel = in_bank(widx, IDX_KERNEL);
    assign is_pixel  = in_bank(widx, IDX_PIXEL);
    assign mapped    = is_ctrl | is_status | is_shift | is_result | is_kernel | is_pixel;

    // Operands of a running MAC are frozen, and a second START cannot be
    // stacked on a running one; such writes are rejected with an error.
    assign tap_locked  = busy & (is_kernel | is_pixel | is_shift | (is_ctrl & PWDATA[0]));
    assign slv_err     = ~mapped | (PWRITE & (is_status | is_result | tap_locked));
    assign PSLVERR     = access_valid & slv_err;
    assign wr_en       = access_valid & PWRITE & ~slv_err;
    assign clear_pulse = wr_en & is_ctrl & PWDATA[1];
    assign start_pulse = wr_en & is_ctrl & PWDATA[0] & ~PWDATA[1];

    // Read mux; bits beyond each field's width read as zero
    always_comb begin
        rd_value = '0;
        if (is_ctrl)        rd_value = {29'b0, relu_en_q, 2'b00};
        else if (is_status) rd_value = {30'b0, done, busy};
        else if (is_shift)  rd_value = {27'b0, shift_q};
        else if (is_result) rd_value = result;
        else begin
            for (int k = 0; k < TAPS; k++) begin
                if (is_kernel && k_off == 6'(k)) rd_value = 32'(kernel_q[k]);
                if (is_pixel  && p_off == 6'(k)) rd_value = 32'(pixel_q[k]);
            end
        end
    end

    assign PRDATA = (access_valid & ~PWRITE & ~slv_err) ? rd_value : '0;

    // Register file; START and CLEAR are not stored, only RELU_EN is held
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            kernel_q  <= '0;
            pixel_q   <= '0;
            shift_q   <= '0;
            relu_en_q <= 1'b0;
        end else if (wr_en) begin
            if (is_ctrl)  relu_en_q <= PWDATA[2];
            if (is_shift) shift_q   <= PWDATA[4:0];
            for (int k = 0; k < TAPS; k++) begin
                if (is_kernel && k_off == 6'(k)) kernel_q[k] <= PWDATA[COEF_W-1:0];
                if (is_pixel  && p_off == 6'(k)) pixel_q[k]  <= PWDATA[PIX_W-1:0];
            end
        end
    end

    conv_mac_unit #(
        .CW (COEF_W),
        .PW (PIX_W),
        .N  (TAPS)
    ) u_mac (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .start   (start_pulse),
        .clear   (clear_pulse),
        .relu_en (relu_en_q),
        .shift   (shift_q),
        .kernel  (kernel_q),
        .pixel   (pixel_q),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

endmodule

// File: tb/tb_apb_conv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_apb_conv_ctrl
// Self-checking bench for apb_conv_ctrl: directed scenarios plus a random
// APB traffic phase, all compared against a behavioural register/MAC model.
// ---------------------------------------------------------------------------
module tb_apb_conv_ctrl;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_SHIFT  = 32'h08;
    localparam logic [31:0] A_RESULT = 32'h0C;
    localparam logic [31:0] A_KERNEL = 32'h10;
    localparam logic [31:0] A_PIXEL  = 32'h40;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Behavioural model state
    logic [7:0]  m_kern [9];
    logic [7:0]  m_pix  [9];
    logic [4:0]  m_shift;
    logic        m_relu;
    logic        m_running;
    logic        m_done;
    logic [31:0] m_result;
    int          m_start_edge;

    apb_conv_ctrl dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    // Clock and an edge counter the model uses to time the 10-cycle run
    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int k = 0; k < 9; k++) begin
            m_kern[k] = '0;
            m_pix[k]  = '0;
        end
        m_shift = '0; m_relu = 1'b0; m_running = 1'b0; m_done = 1'b0;
        m_result = '0; m_start_edge = 0;
    endfunction

    function automatic logic [31:0] conv_result();
        int acc = 0;
        for (int k = 0; k < 9; k++) acc += int'($signed(m_kern[k])) * int'(m_pix[k]);
        acc = acc >>> m_shift;
        if (m_relu && acc < 0) acc = 0;
        return acc;
    endfunction

    // A run started at edge S publishes its result at edge S+10
    function automatic void settle(input int edge_n);
        if (m_running && (edge_n - m_start_edge) >= 10) begin
            m_running = 1'b0;
            m_done    = 1'b1;
            m_result  = conv_result();
        end
    endfunction

    function automatic logic is_mapped(input logic [5:0] w);
        return (w <= 6'd3) || (w >= 6'd4 && w <= 6'd12) || (w >= 6'd16 && w <= 6'd24);
    endfunction

    function automatic logic model_err(input logic [5:0] w, input logic wr, input logic [31:0] d);
        if (!is_mapped(w)) return 1'b1;
        if (!wr) return 1'b0;
        if (w == 6'd1 || w == 6'd3) return 1'b1;
        if (m_running && (w >= 6'd2 || d[0])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [5:0] w);
        if (w == 6'd0) return {29'b0, m_relu, 2'b00};
        if (w == 6'd1) return {30'b0, m_done, m_running};
        if (w == 6'd2) return {27'b0, m_shift};
        if (w == 6'd3) return m_result;
        if (w >= 6'd4 && w <= 6'd12) return {24'b0, m_kern[w - 6'd4]};
        if (w >= 6'd16 && w <= 6'd24) return {24'b0, m_pix[w - 6'd16]};
        return 32'h0;
    endfunction

    function automatic void model_write(input logic [5:0] w, input logic [31:0] d, input int edge_n);
        settle(edge_n);
        if (w == 6'd0) begin
            m_relu = d[2];
            if (d[1]) begin
                m_running = 1'b0; m_done = 1'b0; m_result = '0;
            end else if (d[0]) begin
                m_running = 1'b1; m_done = 1'b0; m_start_edge = edge_n;
            end
        end else if (w == 6'd2) m_shift = d[4:0];
        else if (w >= 6'd4 && w <= 6'd12) m_kern[w - 6'd4] = d[7:0];
        else if (w >= 6'd16 && w <= 6'd24) m_pix[w - 6'd16] = d[7:0];
    endfunction

    // ---------------- bus tasks ----------------
    // One SETUP + ACCESS transfer, entered and left #1 after a clock edge.
    task automatic apb_access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err);
        logic [5:0]  w;
        logic        exp_err;
        logic [31:0] exp_rd;
        string       tag;
        w = addr[7:2];
        tag = $sformatf("%s@%02h", wr ? "wr" : "rd", addr[7:0]);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        #1;
        settle(cyc);
        exp_err = model_err(w, wr, wdata);
        exp_rd  = (wr || exp_err) ? 32'h0 : model_read(w);
        checkOutput({tag, "_pready"},  {31'b0, PREADY},  32'h1);
        checkOutput({tag, "_pslverr"}, {31'b0, PSLVERR}, {31'b0, exp_err});
        checkOutput({tag, "_prdata"},  PRDATA, exp_rd);
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        if (wr && !exp_err) model_write(w, wdata, cyc);
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic        e;
        apb_access(addr, 1'b1, data, rd, e);
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        logic e;
        apb_access(addr, 1'b0, 32'h0, data, e);
    endtask

    task automatic load_taps(input int kern [9], input int pix [9]);
        for (int k = 0; k < 9; k++) apb_write(A_KERNEL + 32'(4 * k), 32'(kern[k]));
        for (int k = 0; k < 9; k++) apb_write(A_PIXEL + 32'(4 * k), 32'(pix[k]));
    endtask

    // Poll STATUS until DONE; returns how many polls still saw BUSY
    task automatic wait_done(input int lead, input string tag, output int busy_polls);
        logic [31:0] st;
        logic        seen;
        seen = 1'b0;
        busy_polls = 0;
        repeat (lead) begin @(posedge HCLK); #1; end
        for (int i = 0; i < 12 && !seen; i++) begin
            apb_read(A_STATUS, st);
            if (st[1]) seen = 1'b1;
            else if (st[0]) busy_polls++;
        end
        checkOutput({tag, "_done_seen"}, {31'b0, seen}, 32'h1);
    endtask

    task automatic do_reset();
        PSEL = 1'b0; PENABLE = 1'b0;
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        checkOutput("rst_prdata",  PRDATA, 32'h0);
        checkOutput("rst_pready",  {31'b0, PREADY}, 32'h0);
        checkOutput("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
        HRESETn = 1'b1;
        model_reset();
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] d;
        for (int i = 0; i <= 24; i++) begin
            if (i >= 13 && i <= 15) continue;
            apb_read(32'(4 * i), d);
            checkOutput($sformatf("%s_reg%02h", tag, 4 * i), d, 32'h0);
        end
    endtask

    // Random APB traffic: tap/shift writes, starts, occasional clears,
    // reads of any address, unmapped accesses and idle gaps.
    task automatic applyStimulus(input int n_ops);
        logic [31:0] rnd, addr, d;
        logic [5:0]  w;
        int          op;
        for (int i = 0; i < n_ops; i++) begin
            op  = $urandom_range(0, 9);
            rnd = $urandom;
            w   = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 24));
            addr = {rnd[31:8], w, rnd[1:0]};
            d = $urandom;
            case (op)
                0, 1: apb_write({rnd[31:8], 6'($urandom_range(4, 12)), rnd[1:0]}, d);
                2:    apb_write({rnd[31:8], 6'($urandom_range(16, 24)), rnd[1:0]}, d);
                3:    apb_write(A_SHIFT, d);
                4:    apb_write(A_CTRL, {d[31:3], d[2], ($urandom_range(0, 7) == 0), d[0] | d[3]});
                5, 6: apb_read(addr, d);
                7:    apb_write(addr, d);
                default: repeat ($urandom_range(0, 6)) begin @(posedge HCLK); #1; end
            endcase
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          kern [9];
        int          pix  [9];
        logic [31:0] d;
        logic        e;
        int          bp;

        model_reset();
        @(posedge HCLK); #1;
        do_reset();
        check_all_zero("reset");

        // Kernel all ones, pixels 1..9 -> 45, busy for 10 cycles
        for (int k = 0; k < 9; k++) begin kern[k] = 1; pix[k] = k + 1; end
        load_taps(kern, pix);
        apb_write(A_CTRL, 32'h1);
        wait_done(0, "sum45", bp);
        checkOutput("sum45_busy_polls", 32'(bp), 32'd5);
        apb_read(A_RESULT, d);
        checkOutput("sum45_result", d, 32'd45);

        // Same taps with SHIFT=1 -> 22; writing a tap while busy is rejected
        apb_write(A_SHIFT, 32'h1);
        apb_write(A_CTRL, 32'h1);
        apb_access(A_KERNEL, 1'b1, 32'h7F, d, e);
        checkOutput("busy_kernel_err", {31'b0, e}, 32'h1);
        apb_read(A_RESULT, d);
        checkOutput("busy_result_held", d, 32'd45);
        wait_done(0, "shift1", bp);
        apb_read(A_RESULT, d);
        checkOutput("shift1_result", d, 32'd22);
        apb_read(A_KERNEL, d);
        checkOutput("busy_kernel_kept", d, 32'd1);

        // Rows {-1,0,1} -> 6, negated -> -6, with ReLU -> 0
        apb_write(A_SHIFT, 32'h0);
        for (int k = 0; k < 9; k++) kern[k] = (k % 3 == 0) ? 8'hFF : ((k % 3 == 2) ? 1 : 0);
        load_taps(kern, pix);
        apb_write(A_CTRL, 32'h1);
        wait_done(1, "rows", bp);
        checkOutput("rows_busy_polls", 32'(bp), 32'd4);
        apb_read(A_RESULT, d);
        checkOutput("rows_result", d, 32'd6);
        for (int k = 0; k < 9; k++) kern[k] = (k % 3 == 0) ? 1 : ((k % 3 == 2) ? 8'hFF : 0);
        load_taps(kern, pix);
        apb_write(A_CTRL, 32'h1);
        wait_done(0, "neg", bp);
        apb_read(A_RESULT, d);
        checkOutput("neg_result", d, 32'hFFFF_FFFA);
        apb_write(A_CTRL, 32'h5);
        wait_done(0, "relu", bp);
        apb_read(A_RESULT, d);
        checkOutput("relu_result", d, 32'h0);
        apb_read(A_CTRL, d);
        checkOutput("relu_ctrl_read", d, 32'h4);

        // Error responses
        apb_access(32'h80, 1'b0, 32'h0, d, e);
        checkOutput("unmapped_err", {31'b0, e}, 32'h1);
        checkOutput("unmapped_data", d, 32'h0);
        apb_access(A_RESULT, 1'b1, 32'h1234, d, e);
        checkOutput("wr_result_err", {31'b0, e}, 32'h1);

        // PENABLE without a SETUP cycle: PREADY follows, nothing is written
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = A_KERNEL; PWDATA = 32'h55;
        #1;
        checkOutput("nosetup_pready", {31'b0, PREADY}, 32'h1);
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        apb_read(A_KERNEL, d);
        checkOutput("nosetup_kernel_kept", d, 32'h1);

        // CLEAR mid-run
        apb_write(A_CTRL, 32'h1);
        wait_done(0, "pre_clear", bp);
        apb_write(A_CTRL, 32'h1);
        repeat (3) begin @(posedge HCLK); #1; end
        apb_write(A_CTRL, 32'h2);
        apb_read(A_STATUS, d);
        checkOutput("clear_status", d, 32'h0);
        apb_read(A_RESULT, d);
        checkOutput("clear_result", d, 32'h0);
        apb_read(A_KERNEL + 32'h8, d);
        checkOutput("clear_taps_kept", d, 32'hFF);

        // Reset mid-run
        apb_write(A_CTRL, 32'h1);
        wait_done(0, "pre_rst", bp);
        apb_write(A_CTRL, 32'h1);
        repeat (2) begin @(posedge HCLK); #1; end
        do_reset();
        check_all_zero("midrst");

        // Randomised traffic against the model
        applyStimulus(300);
        wait_done(0, "rand_final", bp);
        apb_read(A_RESULT, d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
